// File: rtl/da_iq_out.sv
// I/Q sample-pair FIFO feeding a dual-channel DAC.
// A free-running divider produces a DAC update tick every DIV clocks. On each
// tick one I/Q pair is popped, converted to the DAC code format and registered
// onto the DAC data pins. A registered DAC clock/write strobe goes low for the
// first half of each divider period, so data settles before the rising edge.

module da_iq_out #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV        = 4,
    parameter int OUT_FMT    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_i,
    input  logic [DATA_W-1:0]             in_q,
    input  logic                          uf_clr,
    output logic [DATA_W-1:0]             out_da_data_i,
    output logic [DATA_W-1:0]             out_da_data_q,
    output logic                          out_da_clk,
    output logic                          out_da_wr,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);

    localparam logic [CW-1:0]     CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]     CNT_HALF   = CW'(DIV / 2);
    localparam logic [AW:0]       LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] ZERO_CODE  =
        (OUT_FMT == 0) ? {1'b1, (DATA_W - 1)'(0)} : DATA_W'(0);

    // Offset binary flips the sign bit; two's complement passes through.
    function automatic logic [DATA_W-1:0] to_code(input logic [DATA_W-1:0] s);
        if (OUT_FMT == 0)
            to_code = {~s[DATA_W-1], s[DATA_W-2:0]};
        else
            to_code = s;
    endfunction

    logic [CW-1:0]       div_cnt;
    logic [CW-1:0]       div_cnt_nxt;
    logic                tick;
    logic                da_clk_q;

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         level;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   head_i;
    logic [DATA_W-1:0]   head_q;

    // Divider next value, tick decode and FIFO handshake decode.
    always_comb begin
        tick        = (div_cnt == CNT_LAST);
        div_cnt_nxt = tick ? '0 : div_cnt + CW'(1);
        full        = (level == LEVEL_FULL);
        empty       = (level == '0);
        in_ready    = !full && enable && !rst;
        push        = in_valid && in_ready;
        pop         = tick && enable && !empty;
        {head_i, head_q} = mem[rd_ptr];
    end

    // Divider counter and DAC clock; the clock register is loaded from the
    // next count so its level always matches the current count's half.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            da_clk_q <= 1'b0;
        end else begin
            div_cnt  <= div_cnt_nxt;
            da_clk_q <= (div_cnt_nxt >= CNT_HALF);
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_i, in_q};
    end

    // FIFO pointers and occupancy; disabling flushes the buffer.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // DAC data registers: update on tick, hold on underflow, zero when disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_da_data_i <= ZERO_CODE;
            out_da_data_q <= ZERO_CODE;
        end else if (tick) begin
            if (!enable) begin
                out_da_data_i <= ZERO_CODE;
                out_da_data_q <= ZERO_CODE;
            end else if (!empty) begin
                out_da_data_i <= to_code(head_i);
                out_da_data_q <= to_code(head_q);
            end
        end
    end

    // Sticky underflow; a new underflow event outranks a clear request.
    always_ff @(posedge clk) begin
        if (rst)
            underflow <= 1'b0;
        else if (tick && enable && empty)
            underflow <= 1'b1;
        else if (uf_clr)
            underflow <= 1'b0;
    end

    assign out_da_clk = da_clk_q;
    assign out_da_wr  = da_clk_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_da_iq_out.sv
// Bench for da_iq_out: directed vectors; DAC-side expectations are queued by
// the stimulus and checked by a monitor on each rising DAC clock.

module tb_da_iq_out;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       in_valid = 1'b0;
    logic [9:0] in_i = '0;
    logic [9:0] in_q = '0;
    logic       uf_clr = 1'b0;

    logic       ready0, ready1, ready2;
    logic [9:0] di0, dq0, di1, dq1, di2, dq2;
    logic       dclk0, dclk1, dclk2;
    logic       dwr0, dwr1, dwr2;
    logic       uf0, uf1, uf2;
    logic [3:0] lvl0, lvl1, lvl2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0] i;
        logic [9:0] q;
        logic       uf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    da_iq_out u_dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
        .in_ready(ready0), .in_i(in_i), .in_q(in_q), .uf_clr(uf_clr),
        .out_da_data_i(di0), .out_da_data_q(dq0), .out_da_clk(dclk0),
        .out_da_wr(dwr0), .underflow(uf0), .fifo_level(lvl0)
    );

    da_iq_out #(.OUT_FMT(1)) u_fmt1 (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
        .in_ready(ready1), .in_i(in_i), .in_q(in_q), .uf_clr(uf_clr),
        .out_da_data_i(di1), .out_da_data_q(dq1), .out_da_clk(dclk1),
        .out_da_wr(dwr1), .underflow(uf1), .fifo_level(lvl1)
    );

    da_iq_out #(.DIV(32)) u_big (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
        .in_ready(ready2), .in_i(in_i), .in_q(in_q), .uf_clr(uf_clr),
        .out_da_data_i(di2), .out_da_data_q(dq2), .out_da_clk(dclk2),
        .out_da_wr(dwr2), .underflow(uf2), .fifo_level(lvl2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 2 time units after the last reset edge (count = 0).
    task automatic do_reset();
        in_valid = 1'b0;
        uf_clr   = 1'b0;
        rst      = 1'b1;
        #1;
        chk("ready_in_rst", ready0, 0);
        step(2);
        rst = 1'b0;
        #1;
    endtask

    // Monitor: on each rising DAC clock compare against the oldest expectation.
    logic prev_dclk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!prev_dclk && dclk0 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("mon_i", di0, e.i);
            chk("mon_q", dq0, e.q);
            chk("mon_uf", uf0, e.uf);
        end
        prev_dclk = dclk0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(1);

        // Reset state
        do_reset();
        chk("rst_i", di0, 10'h200);
        chk("rst_q", dq0, 10'h200);
        chk("rst_clk", dclk0, 0);
        chk("rst_wr", dwr0, 0);
        chk("rst_uf", uf0, 0);
        chk("rst_lvl", lvl0, 0);
        chk("rst_ready", ready0, 1);
        chk("rst_fmt1_i", di1, 10'h000);

        // Fill a slow-ticking instance: 9 offered, 8 accepted
        in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_i = 10'(k);
            in_q = 10'(k);
            chk("big_ready", ready2, (k < 8) ? 1 : 0);
            step(1);
        end
        in_valid = 1'b0;
        chk("big_lvl", lvl2, 8);
        chk("big_ready_full", ready2, 0);

        // First pair through, DAC clock rises two cycles after the update
        do_reset();
        in_valid = 1'b1;
        in_i = 10'h000;
        in_q = 10'h3FF;
        step(1);
        in_valid = 1'b0;
        chk("lvl_one", lvl0, 1);
        step(3);
        chk("first_i", di0, 10'h200);
        chk("first_q", dq0, 10'h1FF);
        chk("first_lvl", lvl0, 0);
        chk("first_clk_lo", dclk0, 0);
        sb.push_back('{i: 10'h200, q: 10'h1FF, uf: 1'b0});
        step(1);
        chk("clk_lo_1", dclk0, 0);
        step(1);
        chk("clk_hi_2", dclk0, 1);

        // Underflow: hold outputs, sticky flag, clear, and set-wins-over-clear
        step(2);
        chk("uf_set", uf0, 1);
        chk("uf_hold_i", di0, 10'h200);
        chk("uf_hold_q", dq0, 10'h1FF);
        sb.push_back('{i: 10'h200, q: 10'h1FF, uf: 1'b1});
        step(2);
        uf_clr = 1'b1;
        step(1);
        chk("uf_cleared", uf0, 0);
        step(1);
        chk("uf_set_wins", uf0, 1);
        uf_clr = 1'b0;

        // Build level 5, then disable
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                in_i = 10'h155;
                in_q = 10'h2AA;
            end else begin
                in_i = 10'(k * 16);
                in_q = 10'(k * 32);
            end
            step(1);
            if (k == 3) begin
                chk("pop_i", di0, 10'h355);
                chk("pop_q", dq0, 10'h0AA);
                chk("fmt1_i", di1, 10'h155);
                chk("fmt1_q", dq1, 10'h2AA);
                chk("pushpop_lvl", lvl0, 3);
                sb.push_back('{i: 10'h355, q: 10'h0AA, uf: 1'b0});
            end
        end
        in_valid = 1'b0;
        chk("lvl_five", lvl0, 5);
        enable = 1'b0;
        #1;
        chk("dis_ready", ready0, 0);
        step(1);
        chk("dis_lvl", lvl0, 0);
        chk("dis_clk_a", dclk0, 1);
        step(1);
        chk("dis_i", di0, 10'h200);
        chk("dis_q", dq0, 10'h200);
        chk("dis_fmt1_i", di1, 10'h000);
        chk("dis_uf", uf0, 0);
        chk("dis_clk_b", dclk0, 0);
        sb.push_back('{i: 10'h200, q: 10'h200, uf: 1'b0});
        step(1);
        chk("dis_clk_c", dclk0, 0);
        step(1);
        chk("dis_clk_d", dclk0, 1);
        step(1);
        chk("dis_clk_e", dclk0, 1);

        // Re-enable, push on a tick edge (no bypass), then reset mid-stream
        enable   = 1'b1;
        in_valid = 1'b1;
        in_i     = 10'h0FF;
        in_q     = 10'h0FF;
        step(1);
        chk("nobypass_lvl", lvl0, 1);
        chk("nobypass_i", di0, 10'h200);
        step(2);
        in_valid = 1'b0;
        chk("lvl_three", lvl0, 3);
        rst = 1'b1;
        step(1);
        chk("mid_rst_lvl", lvl0, 0);
        chk("mid_rst_i", di0, 10'h200);
        chk("mid_rst_q", dq0, 10'h200);
        chk("mid_rst_clk", dclk0, 0);
        chk("mid_rst_wr", dwr0, 0);
        chk("mid_rst_uf", uf0, 0);
        chk("mid_rst_ready", ready0, 0);
        chk("mid_rst_fmt1", dq1, 10'h000);
        rst = 1'b0;
        #1;
        step(4);
        chk("discard_uf", uf0, 1);
        chk("discard_i", di0, 10'h200);
        chk("discard_lvl", lvl0, 0);

        step(4);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/da_iq_out.md
DA_IQ_OUT -- requirements
Module: da_iq_out

Interface
REQ-001 SHALL have parameter DATA_W, default 10, sample width per channel (4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, sample-pair buffer depth (power of 2, 2..64).
REQ-003 SHALL have parameter DIV, default 4, clk cycles per DAC update (even, 2..256).
REQ-004 SHALL have parameter OUT_FMT, default 0, 0 = offset binary (MSB inverted), 1 = two's complement passthrough.
REQ-005 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port enable  in  1  output enable; 0 = flush and drive zero-code.
REQ-008 SHALL have port in_valid  in  1  sample pair present.
REQ-009 SHALL have port in_ready  out  1  FIFO can accept a pair.
REQ-010 SHALL have port in_i  in  DATA_W  I sample, two's complement.
REQ-011 SHALL have port in_q  in  DATA_W  Q sample, two's complement.
REQ-012 SHALL have port uf_clr  in  1  clears underflow sticky flag.
REQ-013 SHALL have port out_da_data_i  out  DATA_W  I DAC code.
REQ-014 SHALL have port out_da_data_q  out  DATA_W  Q DAC code.
REQ-015 SHALL have port out_da_clk  out  1  DAC clock, registered.
REQ-016 SHALL have port out_da_wr  out  1  DAC write strobe, registered, identical to out_da_clk.
REQ-017 SHALL have port underflow  out  1  sticky underflow flag.
REQ-018 SHALL have port fifo_level  out  clog2(FIFO_DEPTH)+1  pairs stored.

Function
REQ-019 SHALL accept a pair when in_valid && in_ready at a clk edge; in_ready = !full && enable && !rst, registered-free (combinational from FIFO state).
REQ-020 SHALL store I and Q together in a FIFO of FIFO_DEPTH pairs; fifo_level updates the cycle after push/pop, push+pop same cycle leaves level unchanged.
REQ-021 SHALL run a free counter div_cnt 0..DIV-1, wrapping to 0; tick = (div_cnt == DIV-1).
REQ-022 SHALL on a tick edge with enable=1 and FIFO non-empty pop one pair and register the converted codes into out_da_data_i/q.
REQ-023 SHALL convert as: OUT_FMT=0 -> {~s[DATA_W-1], s[DATA_W-2:0]}; OUT_FMT=1 -> s unchanged.
REQ-024 SHALL on a tick edge with enable=1 and FIFO empty hold previous output codes and set underflow.
REQ-025 SHALL keep underflow set until an edge with uf_clr=1; a simultaneous new underflow event wins (flag stays 1).
REQ-026 SHALL drive out_da_clk/out_da_wr low during cycles with div_cnt < DIV/2 and high otherwise, from a register (glitch-free), so data changes DIV/2 cycles before each rising edge.
REQ-027 SHALL when enable=0: empty the FIFO on the next edge, force in_ready=0, drive zero-code on both channels at the next tick; counter and out_da_clk keep running.
REQ-028 SHALL define zero-code as {1,0...0} for OUT_FMT=0 and all-zeros for OUT_FMT=1.
REQ-029 SHALL allow a push in the same cycle as a tick-pop when FIFO is empty only if level was nonzero before; a pair pushed on the tick edge is not popped until the next tick (no bypass).
REQ-030 SHALL have output data latency of exactly one tick boundary from FIFO head to outputs.

Reset
REQ-031 SHALL on rst=1 at an edge: FIFO empty, fifo_level=0, div_cnt=0, out_da_clk=out_da_wr=0, outputs = zero-code, underflow=0.
REQ-032 SHALL apply reset mid-operation identically, discarding stored pairs; rst has priority over enable, push, tick and uf_clr.

Verification
REQ-033 SHALL verify: defaults, reset then push I=0x000,Q=0x3FF -> after next tick out_da_data_i=0x200, out_da_data_q=0x1FF, out_da_clk rises 2 cycles later.
REQ-034 SHALL verify: push 9 pairs back-to-back with enable=1 before any tick -> in_ready drops after 8th, fifo_level=8, 9th not accepted.
REQ-035 SHALL verify: one pair pushed then 2 ticks -> second tick holds value and underflow=1; uf_clr pulse -> underflow=0; uf_clr on an underflow tick -> underflow stays 1.
REQ-036 SHALL verify: enable deasserted with level=5 -> level=0 next cycle, outputs 0x200/0x200 at next tick, out_da_clk still toggling every 2 cycles.
REQ-037 SHALL verify: rst asserted mid-stream with level=3 -> all outputs at REQ-031 values next cycle; OUT_FMT=1 build -> zero-code 0x000 and I=0x155 passes as 0x155.
